// File: rtl/intersection_multi.sv
// Multi-phase traffic controller: CLEAR/GREEN/PED sequencing with latched vehicle and pedestrian demand.
// Latency: a demand latched at one edge can be granted at the next edge once clearance has expired; all outputs registered.
// Backpressure: none; requests are sticky and wait until served.
module intersection_multi #(
    parameter int NUM_PHASES = 4,
    parameter int GREEN_TIME = 16,
    parameter int CLEAR_TIME = 4,
    parameter int PED_TIME   = 10
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  actuated,
    input  logic [NUM_PHASES-1:0] phase_req,
    input  logic                  ped_button,
    output logic [NUM_PHASES-1:0] phase_green,
    output logic                  ped_green,
    output logic                  clearing,
    output logic [2:0]            cur_phase
);

    typedef enum logic [1:0] {S_CLEAR, S_GREEN, S_PED} state_t;

    state_t                state, state_nxt;
    logic [7:0]            cnt, cnt_nxt;
    logic [2:0]            next_ptr, next_ptr_nxt, cur_nxt;
    logic [NUM_PHASES-1:0] demand, demand_nxt;
    logic                  ped_pending, ped_pending_nxt;
    logic [NUM_PHASES-1:0] phase_green_nxt;
    logic                  ped_green_nxt, clearing_nxt;
    logic                  expired;

    logic [NUM_PHASES-1:0] rot;
    logic [2:0]            scan_off, scan_phase, grant;
    logic [3:0]            scan_sum;
    logic                  scan_found;

    assign expired = (cnt <= 8'd1);

    // Rotate demand so bit 0 is next_ptr; the lowest set bit is the nearest phase in service order.
    always_comb begin
        rot        = NUM_PHASES'({demand, demand} >> next_ptr);
        scan_found = 1'b0;
        scan_off   = 3'd0;
        for (int j = NUM_PHASES - 1; j >= 0; j--) begin
            if (rot[j]) begin
                scan_found = 1'b1;
                scan_off   = 3'(j);
            end
        end
        scan_sum = {1'b0, next_ptr} + {1'b0, scan_off};
        if (scan_sum >= 4'(NUM_PHASES)) begin
            scan_sum = scan_sum - 4'(NUM_PHASES);
        end
        scan_phase = scan_sum[2:0];
    end

    always_comb begin
        state_nxt       = state;
        cnt_nxt         = (cnt != 8'd0) ? cnt - 8'd1 : 8'd0;
        next_ptr_nxt    = next_ptr;
        cur_nxt         = cur_phase;
        grant           = actuated ? scan_phase : next_ptr;
        // Requests for whatever is currently being served are ignored.
        demand_nxt      = demand | (phase_req & ~phase_green);
        ped_pending_nxt = ped_pending | (ped_button & ~ped_green);

        case (state)
            S_CLEAR: begin
                if (expired) begin
                    if (ped_pending) begin
                        state_nxt       = S_PED;
                        cnt_nxt         = 8'(PED_TIME);
                        ped_pending_nxt = 1'b0;
                    end else if (!actuated || scan_found) begin
                        state_nxt  = S_GREEN;
                        cnt_nxt    = 8'(GREEN_TIME);
                        cur_nxt    = grant;
                        demand_nxt = demand_nxt & ~(NUM_PHASES'(1) << grant);
                    end
                end
            end
            S_GREEN: begin
                if (expired) begin
                    state_nxt    = S_CLEAR;
                    cnt_nxt      = 8'(CLEAR_TIME);
                    next_ptr_nxt = (cur_phase == 3'(NUM_PHASES - 1)) ? 3'd0 : cur_phase + 3'd1;
                end
            end
            S_PED: begin
                if (expired) begin
                    state_nxt = S_CLEAR;
                    cnt_nxt   = 8'(CLEAR_TIME);
                end
            end
            default: begin
                state_nxt = S_CLEAR;
                cnt_nxt   = 8'(CLEAR_TIME);
            end
        endcase

        phase_green_nxt = (state_nxt == S_GREEN) ? (NUM_PHASES'(1) << cur_nxt) : '0;
        ped_green_nxt   = (state_nxt == S_PED);
        clearing_nxt    = (state_nxt == S_CLEAR);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= S_CLEAR;
            cnt         <= 8'(CLEAR_TIME);
            next_ptr    <= 3'd0;
            cur_phase   <= 3'd0;
            demand      <= '0;
            ped_pending <= 1'b0;
            phase_green <= '0;
            ped_green   <= 1'b0;
            clearing    <= 1'b1;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            next_ptr    <= next_ptr_nxt;
            cur_phase   <= cur_nxt;
            demand      <= demand_nxt;
            ped_pending <= ped_pending_nxt;
            phase_green <= phase_green_nxt;
            ped_green   <= ped_green_nxt;
            clearing    <= clearing_nxt;
        end
    end

endmodule
